// File: rtl/main_mem_responder_pkg.sv
// Shared memory-system definitions: word width, default responder timing
// and geometry, and the request decode type.
package main_mem_responder_pkg;

    localparam int WORD_W          = 16;
    localparam int ADDR_W          = 16;
    localparam int DEF_LATENCY     = 4;
    localparam int DEF_WORD_ADDR_W = 10;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        REQ_NONE  = 2'd0,
        REQ_READ  = 2'd1,
        REQ_WRITE = 2'd2
    } req_kind_e;

endpackage

// File: rtl/main_mem_responder_if.sv
// Request/response bus between a memory requester and the main-memory
// responder. The requester drives the request side; the responder returns
// read data with a one-cycle valid strobe.
interface main_mem_responder_if;
    import main_mem_responder_pkg::*;

    logic  enable;
    logic  wr;
    addr_t addr;
    word_t data_in;
    word_t data_out;
    logic  data_valid;

    modport master (
        output enable, wr, addr, data_in,
        input  data_out, data_valid
    );

    modport slave (
        input  enable, wr, addr, data_in,
        output data_out, data_valid
    );

endinterface

// File: rtl/main_mem_responder_lat_pipe.sv
// Fixed-latency delay line of {valid, data} stages. Valid bits shift every
// cycle; a data stage only loads when the entry arriving at it is valid, so
// the last stage keeps the most recent response while no response is
// emerging.
module mem_lat_pipe #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_q [DEPTH];
    logic [WIDTH-1:0] data_q  [DEPTH];

    // Shift the stages; reset drops everything in flight and zeroes the data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                data_q[i]  <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            if (in_valid) begin
                data_q[0] <= in_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/main_mem_responder.sv
// Main-memory responder: a word array that accepts one request per cycle,
// performs writes immediately and returns read data a fixed number of
// cycles after acceptance, in order, through a delay line.
module main_mem_responder
    import main_mem_responder_pkg::*;
#(
    parameter int LATENCY     = DEF_LATENCY,
    parameter int WORD_ADDR_W = DEF_WORD_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    main_mem_responder_if.slave  bus
);

    localparam int DEPTH = 2 ** WORD_ADDR_W;

    word_t                  mem [DEPTH];
    logic [WORD_ADDR_W-1:0] word_idx;
    req_kind_e              req_kind;
    logic                   rd_accept;
    logic                   wr_accept;
    word_t                  rd_word;
    logic                   unused_addr;

    // Byte bit 0 and the bits above the array size take no part in decode,
    // so addresses differing only there alias the same word.
    assign word_idx    = bus.addr[WORD_ADDR_W:1];
    assign unused_addr = ^bus.addr;

    // Classify the request; nothing is accepted while reset is held.
    always_comb begin
        req_kind = REQ_NONE;
        if (rst && bus.enable) begin
            req_kind = bus.wr ? REQ_WRITE : REQ_READ;
        end
    end

    assign rd_accept = (req_kind == REQ_READ);
    assign wr_accept = (req_kind == REQ_WRITE);

    // Read happens at the acceptance edge, so a later write cannot leak into
    // a read already in flight and an earlier write is always visible.
    assign rd_word = mem[word_idx];

    // Array write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[word_idx] <= bus.data_in;
        end
    end

    mem_lat_pipe #(
        .DEPTH (LATENCY),
        .WIDTH (WORD_W)
    ) u_lat_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_accept),
        .in_data   (rd_word),
        .out_valid (bus.data_valid),
        .out_data  (bus.data_out)
    );

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed, table-driven bench for main_mem_responder: one instance at the
// default latency and one built with LATENCY=1. Each table row is one clock
// cycle: the inputs driven during that cycle and the outputs expected
// during that same cycle.
module tb_main_mem_responder;

    typedef struct {
        logic        rst_n;
        logic        en;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic        exp_v;
        logic [15:0] exp_d;
    } vec_t;

    logic clk;
    logic rst;
    int   n_err;
    int   n_chk;
    vec_t tab4[$];
    vec_t tab1[$];

    main_mem_responder_if bus4();
    main_mem_responder_if bus1();

    main_mem_responder dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    main_mem_responder #(.LATENCY(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic e, logic w, logic [15:0] a,
                                logic [15:0] d, logic ev, logic [15:0] ed);
        vec_t v;
        v.rst_n = r; v.en = e; v.wr = w; v.addr = a; v.din = d;
        v.exp_v = ev; v.exp_d = ed;
        return v;
    endfunction

    task automatic chk(string name, int row, logic [15:0] act, logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    // Drive row inputs at the falling edge and compare the outputs that the
    // preceding rising edge produced.
    task automatic run_row(int sel, int row, vec_t v);
        rst = v.rst_n;
        if (sel == 4) begin
            bus4.enable = v.en; bus4.wr = v.wr; bus4.addr = v.addr; bus4.data_in = v.din;
            bus1.enable = 1'b0;
            chk("lat4_valid", row, {15'd0, bus4.data_valid}, {15'd0, v.exp_v});
            chk("lat4_data",  row, bus4.data_out, v.exp_d);
        end else begin
            bus1.enable = v.en; bus1.wr = v.wr; bus1.addr = v.addr; bus1.data_in = v.din;
            bus4.enable = 1'b0;
            chk("lat1_valid", row, {15'd0, bus1.data_valid}, {15'd0, v.exp_v});
            chk("lat1_data",  row, bus1.data_out, v.exp_d);
        end
        @(negedge clk);
    endtask

    initial begin
        n_err = 0;
        n_chk = 0;
        rst = 1'b0;
        bus4.enable = 1'b0; bus4.wr = 1'b0; bus4.addr = '0; bus4.data_in = '0;
        bus1.enable = 1'b0; bus1.wr = 1'b0; bus1.addr = '0; bus1.data_in = '0;

        // LATENCY=4 instance
        //            rst   en    wr    addr      din       v     data
        tab4.push_back(mk(1'b1, 1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000)); // 0
        tab4.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000)); // 1
        tab4.push_back(mk(1'b1, 1'b1, 1'b1, 16'h0040, 16'h1000, 1'b0, 16'h0000));
        tab4.push_back(mk(1'b1, 1'b1, 1'b1, 16'h0042, 16'h1001, 1'b0, 16'h0000));
        tab4.push_back(mk(1'b1, 1'b1, 1'b1, 16'h0044, 16'h1002, 1'b0, 16'h0000));
        tab4.push_back(mk(1'b1, 1'b1, 1'b1, 16'h0046, 16'h1003, 1'b1, 16'hBEEF)); // 5
        tab4.push_back(mk(1'b1, 1'b1, 1'b1, 16'h0048, 16'h1004, 1'b0, 16'hBEEF));
        tab4.push_back(mk(1'b1, 1'b1, 1'b1, 16'h004A, 16'h1005, 1'b0, 16'hBEEF));
        tab4.push_back(mk(1'b1, 1'b1, 1'b1, 16'h004C, 16'h1006, 1'b0, 16'hBEEF));
        tab4.push_back(mk(1'b1, 1'b1, 1'b1, 16'h004E, 16'h1007, 1'b0, 16'hBEEF));
        tab4.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 16'hBEEF)); // 10
        tab4.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0042, 16'h0000, 1'b0, 16'hBEEF));
        tab4.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0044, 16'h0000, 1'b0, 16'hBEEF));
        tab4.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0046, 16'h0000, 1'b0, 16'hBEEF));
        tab4.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0048, 16'h0000, 1'b1, 16'h1000));
        tab4.push_back(mk(1'b1, 1'b1, 1'b0, 16'h004A, 16'h0000, 1'b1, 16'h1001)); // 15
        tab4.push_back(mk(1'b1, 1'b1, 1'b0, 16'h004C, 16'h0000, 1'b1, 16'h1002));
        tab4.push_back(mk(1'b1, 1'b1, 1'b0, 16'h004E, 16'h0000, 1'b1, 16'h1003));
        tab4.push_back(mk(1'b1, 1'b1, 1'b1, 16'h0020, 16'h1111, 1'b1, 16'h1004));
        tab4.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 16'h1005));
        tab4.push_back(mk(1'b1, 1'b1, 1'b1, 16'h0020, 16'h2222, 1'b1, 16'h1006)); // 20
        tab4.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 16'h1007));
        tab4.push_back(mk(1'b1, 1'b1, 1'b1, 16'h0003, 16'hA5A5, 1'b0, 16'h1007));
        tab4.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b1, 16'h1111));
        tab4.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0802, 16'h0000, 1'b0, 16'h1111));
        tab4.push_back(mk(1'b1, 1'b0, 1'b1, 16'h0002, 16'hFFFF, 1'b1, 16'h2222)); // 25
        tab4.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h2222));
        tab4.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b1, 16'hA5A5));
        tab4.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hA5A5));
        tab4.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'hA5A5));
        tab4.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'hA5A5)); // 30
        tab4.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hA5A5));
        tab4.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'hA5A5));
        tab4.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 16'hA5A5));
        tab4.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0042, 16'h0000, 1'b0, 16'hA5A5));
        tab4.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0044, 16'h0000, 1'b0, 16'hA5A5)); // 35
        tab4.push_back(mk(1'b0, 1'b1, 1'b1, 16'h0040, 16'hDEAD, 1'b0, 16'hA5A5));
        tab4.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 16'h0000));
        tab4.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000));
        tab4.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000));
        tab4.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000)); // 40
        tab4.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1000));
        tab4.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h1000));

        // LATENCY=1 instance
        tab1.push_back(mk(1'b1, 1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000)); // 0
        tab1.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000));
        tab1.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hBEEF));
        tab1.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'hBEEF));
        tab1.push_back(mk(1'b1, 1'b1, 1'b1, 16'h0012, 16'h1234, 1'b0, 16'hBEEF));
        tab1.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0012, 16'h0000, 1'b0, 16'hBEEF)); // 5
        tab1.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1234));
        tab1.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h1234));
        tab1.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0012, 16'h0000, 1'b1, 16'hBEEF));
        tab1.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1234));
        tab1.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h1234)); // 10

        repeat (3) @(negedge clk);

        for (int i = 0; i < tab4.size(); i++) begin
            run_row(4, i, tab4[i]);
        end
        for (int i = 0; i < tab1.size(); i++) begin
            run_row(1, i, tab1[i]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/main_mem_responder.md
MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

Interface
REQ-001 SHALL have parameter: LATENCY, default 4, cycles from read acceptance to data_valid (legal range 1..8).
REQ-002 SHALL have parameter: WORD_ADDR_W, default 10, number of word-address bits; array depth is 2**WORD_ADDR_W 16-bit words.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: rst  input  1  reset; synchronous and active-low.
REQ-005 SHALL have port: enable  input  1  request strobe; one request is accepted per cycle in which it is high.
REQ-006 SHALL have port: wr  input  1  request type, sampled with enable: 1 = write, 0 = read.
REQ-007 SHALL have port: addr  input  16  byte address; bit 0 ignored; bits [WORD_ADDR_W:1] select the word.
REQ-008 SHALL have port: data_in  input  16  write data, sampled with enable&wr.
REQ-009 SHALL have port: data_out  output  16  read response data.
REQ-010 SHALL have port: data_valid  output  1  high for exactly one cycle per accepted read.

Function
REQ-011 SHALL accept a request in every cycle with enable=1; no backpressure, no busy output.
REQ-012 SHALL, for enable&wr, write data_in to the selected word at that clock edge and produce no response.
REQ-013 SHALL, for enable&!wr, capture the selected word's value at the acceptance edge and present it on data_out with data_valid=1 exactly LATENCY cycles later (a read accepted in cycle N responds in cycle N+LATENCY).
REQ-014 SHALL return responses in acceptance order, one per cycle for back-to-back reads, with no bubbles or drops.
REQ-015 SHALL give write-then-read ordering: a read accepted in any cycle after a write to the same word returns the new data.
REQ-016 SHALL give read-then-write ordering: a read accepted before a write to the same word returns the old data, even while the read is still in flight.
REQ-017 SHALL ignore addr bits above WORD_ADDR_W, so addresses that differ only in those bits alias the same word.
REQ-018 SHALL hold data_out at its last response value while data_valid=0.
REQ-019 SHALL implement the latency as a LATENCY-deep shift pipeline of {valid, data} stages; no other state is required.
REQ-020 SHALL ignore wr, addr and data_in when enable=0.

Reset
REQ-021 SHALL, while rst=0 at a clock edge, clear all pipeline valid bits, drive data_valid=0 and data_out=16'h0000, and accept no requests.
REQ-022 SHALL discard all reads in flight when reset is asserted; no data_valid may appear for them after reset is released.
REQ-023 SHALL leave memory array contents unaffected by reset.
REQ-024 SHALL accept requests from the first edge with rst=1; a read accepted at that edge responds LATENCY cycles later.

Structure
REQ-025 SHALL take WORD_W=16, the default LATENCY and the default WORD_ADDR_W from the shared memory-system package used by the cache and fill logic.
REQ-026 SHALL place the delay line in one sub-module, mem_lat_pipe, parameterized by depth and data width; the array and request decode stay in main_mem_responder.

Verification
REQ-027 SHALL cover: write 16'hBEEF to addr 16'h0010, then read 16'h0010 in the next cycle -> data_valid=1 with data_out=16'hBEEF exactly 4 cycles after the read cycle.
REQ-028 SHALL cover: preload words 16'h0040..16'h004E with 16'h1000+i, then issue 8 back-to-back reads -> 8 consecutive data_valid cycles carrying 16'h1000..16'h1007 in order, starting 4 cycles after the first read.
REQ-029 SHALL cover: read 16'h0020 (holding 16'h1111), then write 16'h2222 to 16'h0020 in the next cycle -> the response is 16'h1111, and a later read returns 16'h2222.
REQ-030 SHALL cover: issue 3 reads, then assert rst=0 two cycles later for 1 cycle -> no data_valid is seen for those reads, and data_out=16'h0000 after reset.
REQ-031 SHALL cover: write 16'hA5A5 to 16'h0003, then read 16'h0002 and, with WORD_ADDR_W=10, read 16'h0802 -> both responses are 16'hA5A5 (bit-0 ignore and aliasing).
REQ-032 SHALL cover: build with LATENCY=1, read following a write -> the response appears on the cycle right after the read, with an idle gap held at the last value.
